// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS execute-stage multiply/divide unit.
// Holds the operation encoding, FSM states and iteration/latency constants.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } muldiv_state_t;

    localparam int MD_ITER    = 32;
    localparam int MD_LATENCY = 34;

endpackage

// File: rtl/mips_cpu_negate.sv
// Conditional two's-complement negate, used for operand abs and result sign fix-up.
// Latency: combinational.
// Backpressure: none.
module mips_cpu_negate #(
    parameter int W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    assign dout = neg ? (~din + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning Hi/Lo, with MTHI/MTLO writes and combinational reads.
// Latency: done pulses 34 cycles after the start edge, one result bit per cycle.
// Backpressure: busy high while in flight; start/hi_we/lo_we are ignored until busy drops.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] LAST_ITER = 5'(MD_ITER - 1);

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q;
    logic [4:0]       count_q;
    logic             sign_a_q, sign_b_q, bzero_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    // acc_q is the product high half (multiply) or partial remainder (divide);
    // sreg_q is the multiplier shifting out (multiply) or dividend-in/quotient-out (divide).
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] opnd_q;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed, rem_fixed;

    mips_cpu_negate #(.W(WIDTH)) u_abs_a (
        .neg  (~op[0] & A[WIDTH-1]),
        .din  (A),
        .dout (abs_a)
    );

    mips_cpu_negate #(.W(WIDTH)) u_abs_b (
        .neg  (~op[0] & B[WIDTH-1]),
        .din  (B),
        .dout (abs_b)
    );

    mips_cpu_negate #(.W(2*WIDTH)) u_fix_prod (
        .neg  (sign_a_q ^ sign_b_q),
        .din  ({acc_q[WIDTH-1:0], sreg_q}),
        .dout (prod_fixed)
    );

    // A zero divisor keeps the all-ones quotient regardless of the dividend sign.
    mips_cpu_negate #(.W(WIDTH)) u_fix_quot (
        .neg  ((sign_a_q ^ sign_b_q) & ~bzero_q),
        .din  (sreg_q),
        .dout (quot_fixed)
    );

    mips_cpu_negate #(.W(WIDTH)) u_fix_rem (
        .neg  (sign_a_q),
        .din  (acc_q[WIDTH-1:0]),
        .dout (rem_fixed)
    );

    always_comb begin
        mul_sum   = acc_q + (sreg_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q[WIDTH-1:0], sreg_q[WIDTH-1]};
        div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (start) state_d = MD_CALC;
            MD_CALC: if (count_q == LAST_ITER) state_d = MD_FIX;
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= MD_MULT;
            count_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            bzero_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            acc_q    <= '0;
            sreg_q   <= '0;
            opnd_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (start) begin
                        op_q     <= muldiv_op_t'(op);
                        sign_a_q <= ~op[0] & A[WIDTH-1];
                        sign_b_q <= ~op[0] & B[WIDTH-1];
                        bzero_q  <= (B == '0);
                        busy_q   <= 1'b1;
                        count_q  <= '0;
                        acc_q    <= '0;
                        if (op[1]) begin
                            sreg_q <= abs_a;
                            opnd_q <= abs_b;
                        end else begin
                            sreg_q <= abs_b;
                            opnd_q <= abs_a;
                        end
                    end else begin
                        if (hi_we) hi_q <= wdata;
                        if (lo_we) lo_q <= wdata;
                    end
                end
                MD_CALC: begin
                    count_q <= count_q + 5'd1;
                    if (op_q == MD_DIV || op_q == MD_DIVU) begin
                        if (!div_trial[WIDTH+1]) begin
                            acc_q  <= div_trial[WIDTH:0];
                            sreg_q <= {sreg_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_q  <= div_shift;
                            sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_q  <= {1'b0, mul_sum[WIDTH:1]};
                        sreg_q <= {mul_sum[0], sreg_q[WIDTH-1:1]};
                    end
                end
                MD_FIX: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    if (op_q == MD_DIV || op_q == MD_DIVU) begin
                        hi_q <= rem_fixed;
                        lo_q <= quot_fixed;
                    end else begin
                        hi_q <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: expected Hi/Lo queued at start, popped on done.
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A, B;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    int          checks = 0;
    int          passed = 0;
    int          fails  = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mips_cpu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                got = sb.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, got.hi});
                check("result_lo", {32'd0, lo}, {32'd0, got.lo});
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input bit disturb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        hi_we = disturb;
        lo_we = 1'b0;
        wdata = 32'hDEAD_BEEF;
        sb.push_back('{hi: eh, lo: el});
        for (int k = 1; k <= MD_LATENCY; k++) begin
            @(negedge clk);
            check($sformatf("busy_c%0d", k), {63'd0, busy}, {63'd0, (k < MD_LATENCY)});
            check($sformatf("done_c%0d", k), {63'd0, done}, {63'd0, (k == MD_LATENCY)});
            if (k == 10 || k == MD_LATENCY - 1) begin
                check($sformatf("hold_hi_c%0d", k), {32'd0, hi}, {32'd0, m_hi});
                check($sformatf("hold_lo_c%0d", k), {32'd0, lo}, {32'd0, m_lo});
            end
            if (disturb && k == 10) begin
                start = 1'b1;
                hi_we = 1'b1;
                lo_we = 1'b1;
                op    = MD_DIVU;
                wdata = 32'h1357_9BDF;
            end else begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
            end
        end
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        A     = '0;
        B     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        #2;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        do_op(MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        do_op(MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        do_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        do_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op(MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
        do_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        do_op(MD_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b0);
        do_op(MD_DIV,   32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);

        // MTHI/MTLO in idle, including both enables in one cycle.
        @(negedge clk);
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0F0F_0F0F;
        @(negedge clk);
        check("mt_both_hi", {32'd0, hi}, 64'h0F0F_0F0F);
        check("mt_both_lo", {32'd0, lo}, 64'h0F0F_0F0F);
        lo_we = 1'b0;
        wdata = 32'hAAAA_0000;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, 64'hAAAA_0000);
        check("mthi_lo", {32'd0, lo}, 64'h0F0F_0F0F);
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'h0000_5555;
        @(negedge clk);
        check("mtlo_hi", {32'd0, hi}, 64'hAAAA_0000);
        check("mtlo_lo", {32'd0, lo}, 64'h0000_5555);
        lo_we = 1'b0;
        m_hi  = 32'hAAAA_0000;
        m_lo  = 32'h0000_5555;

        // Writes alongside start and while busy must be dropped.
        do_op(MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);

        // Asynchronous abort of a divide mid-flight.
        @(negedge clk);
        start = 1'b1;
        op    = MD_DIV;
        A     = 32'hFFFF_FF00;
        B     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_idle_busy", {63'd0, busy}, 64'd0);

        do_op(MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

        @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
